// File: rtl/tdc_encode_scheduler_pkg.sv
// Shared widths, flag positions and FSM encoding for the TDC encode scheduler.
package tdc_encode_scheduler_pkg;

  localparam int unsigned DFF_W  = 63;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned CODE_W = 10;
  localparam int unsigned FLAG_W = 3;

  localparam int unsigned FLAG_TOA_ERR  = 0;
  localparam int unsigned FLAG_TOT_ERR  = 1;
  localparam int unsigned FLAG_TOT_MISS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL_TOA,
    ST_WAIT_TOT,
    ST_SEL_TOT,
    ST_OUT
  } state_e;

endpackage

// File: rtl/tdc_capture_hold.sv
// One-deep hold for a raw TDC capture; a load coinciding with release is accepted.
module tdc_capture_hold
  import tdc_encode_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             release_i,
  input  logic [DFF_W-1:0] raw_i,
  input  logic [CNT_W-1:0] cnt_a_i,
  input  logic [CNT_W-1:0] cnt_b_i,
  output logic [DFF_W-1:0] raw_o,
  output logic [CNT_W-1:0] cnt_a_o,
  output logic [CNT_W-1:0] cnt_b_o,
  output logic             full_o,
  output logic             drop_o
);

  logic             full_q;
  logic [DFF_W-1:0] raw_q;
  logic [CNT_W-1:0] cnt_a_q;
  logic [CNT_W-1:0] cnt_b_q;
  logic             accept;

  assign accept = load_i && (!full_q || release_i);
  assign drop_o = load_i && full_q && !release_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q  <= 1'b0;
      raw_q   <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (accept) begin
      full_q  <= 1'b1;
      raw_q   <= raw_i;
      cnt_a_q <= cnt_a_i;
      cnt_b_q <= cnt_b_i;
    end else if (release_i) begin
      full_q  <= 1'b0;
    end
  end

  assign raw_o   = raw_q;
  assign cnt_a_o = cnt_a_q;
  assign cnt_b_o = cnt_b_q;
  assign full_o  = full_q;

endmodule

// File: rtl/tdc_encode_scheduler.sv
// Shares one TOA encoder between the TOA and TOT capture paths and pairs the
// two codes into a hit record offered on a valid/ready interface.
module tdc_encode_scheduler
  import tdc_encode_scheduler_pkg::*;
#(
  parameter int unsigned ENC_LAT     = 2,
  parameter int unsigned TOT_TIMEOUT = 15,
  parameter int unsigned DROP_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              toa_valid,
  input  logic [DFF_W-1:0]  toa_raw,
  input  logic [CNT_W-1:0]  toa_cntA,
  input  logic [CNT_W-1:0]  toa_cntB,
  input  logic              tot_valid,
  input  logic [DFF_W-1:0]  tot_raw,
  input  logic [CNT_W-1:0]  tot_cntA,
  input  logic [CNT_W-1:0]  tot_cntB,
  output logic [DFF_W-1:0]  enc_A,
  output logic [CNT_W-1:0]  enc_cntA,
  output logic [CNT_W-1:0]  enc_cntB,
  input  logic [2:0]        enc_coarse,
  input  logic [6:0]        enc_fine,
  input  logic              enc_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_toa,
  output logic [CODE_W-1:0] out_tot,
  output logic [FLAG_W-1:0] out_flags,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              busy
);

  localparam int unsigned TMR_MAX = (TOT_TIMEOUT > ENC_LAT) ? TOT_TIMEOUT : ENC_LAT;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] LAT_LOAD = TMR_W'(ENC_LAT - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD = TMR_W'(TOT_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [DROP_W:0]  DROP_MAX = {1'b0, {DROP_W{1'b1}}};

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [CODE_W-1:0]   toa_code_q, toa_code_d;
  logic [CODE_W-1:0]   tot_code_q, tot_code_d;
  logic [FLAG_W-1:0]   flags_q, flags_d;
  logic [DROP_W-1:0]   drop_q, drop_d;
  logic [DROP_W:0]     drop_sum;

  logic [DFF_W-1:0]    toa_h_raw, tot_h_raw;
  logic [CNT_W-1:0]    toa_h_a, toa_h_b, tot_h_a, tot_h_b;
  logic                toa_full, tot_full, toa_drop, tot_drop;
  logic                toa_rel, tot_rel;

  tdc_capture_hold u_toa_hold (
    .clk       (clk),
    .reset     (reset),
    .load_i    (toa_valid),
    .release_i (toa_rel),
    .raw_i     (toa_raw),
    .cnt_a_i   (toa_cntA),
    .cnt_b_i   (toa_cntB),
    .raw_o     (toa_h_raw),
    .cnt_a_o   (toa_h_a),
    .cnt_b_o   (toa_h_b),
    .full_o    (toa_full),
    .drop_o    (toa_drop)
  );

  tdc_capture_hold u_tot_hold (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tot_valid),
    .release_i (tot_rel),
    .raw_i     (tot_raw),
    .cnt_a_i   (tot_cntA),
    .cnt_b_i   (tot_cntB),
    .raw_o     (tot_h_raw),
    .cnt_a_o   (tot_h_a),
    .cnt_b_o   (tot_h_b),
    .full_o    (tot_full),
    .drop_o    (tot_drop)
  );

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    toa_code_d = toa_code_q;
    tot_code_d = tot_code_q;
    flags_d    = flags_q;
    toa_rel    = 1'b0;
    tot_rel    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (toa_full) begin
          state_d = ST_SEL_TOA;
          tmr_d   = LAT_LOAD;
        end
      end
      ST_SEL_TOA: begin
        if (tmr_q == '0) begin
          toa_code_d              = {enc_coarse, enc_fine};
          flags_d                 = '0;
          flags_d[FLAG_TOA_ERR]   = enc_err;
          toa_rel                 = 1'b1;
          state_d                 = ST_WAIT_TOT;
          tmr_d                   = TMO_LOAD;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_WAIT_TOT: begin
        // Timeout fires when the decremented count would reach zero, so the
        // FSM spends exactly TOT_TIMEOUT cycles here.
        if (tot_full) begin
          state_d = ST_SEL_TOT;
          tmr_d   = LAT_LOAD;
        end else if (tmr_q <= TMR_ONE) begin
          tot_code_d              = '0;
          flags_d[FLAG_TOT_MISS]  = 1'b1;
          state_d                 = ST_OUT;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_SEL_TOT: begin
        if (tmr_q == '0) begin
          tot_code_d              = {enc_coarse, enc_fine};
          flags_d[FLAG_TOT_ERR]   = enc_err;
          tot_rel                 = 1'b1;
          state_d                 = ST_OUT;
        end else begin
          tmr_d = tmr_q - TMR_ONE;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          if (toa_full) begin
            state_d = ST_SEL_TOA;
            tmr_d   = LAT_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    enc_A    = '0;
    enc_cntA = '0;
    enc_cntB = '0;
    if (state_q == ST_SEL_TOA) begin
      enc_A    = toa_h_raw;
      enc_cntA = toa_h_a;
      enc_cntB = toa_h_b;
    end else if (state_q == ST_SEL_TOT) begin
      enc_A    = tot_h_raw;
      enc_cntA = tot_h_a;
      enc_cntB = tot_h_b;
    end
  end

  always_comb begin
    drop_sum = {1'b0, drop_q} + {{DROP_W{1'b0}}, toa_drop} + {{DROP_W{1'b0}}, tot_drop};
    drop_d   = (drop_sum > DROP_MAX) ? '1 : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      toa_code_q <= '0;
      tot_code_q <= '0;
      flags_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      toa_code_q <= toa_code_d;
      tot_code_q <= tot_code_d;
      flags_q    <= flags_d;
      drop_q     <= drop_d;
    end
  end

  assign out_valid = (state_q == ST_OUT);
  assign busy      = (state_q != ST_IDLE);
  assign out_toa   = toa_code_q;
  assign out_tot   = tot_code_q;
  assign out_flags = flags_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_tdc_encode_scheduler.sv
// Directed bench for tdc_encode_scheduler with a combinational encoder model:
// coarse = cntA + cntB, fine = A[6:0], err = A[62].
module tb_tdc_encode_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        toa_valid, tot_valid;
  logic [62:0] toa_raw, tot_raw;
  logic [2:0]  toa_cntA, toa_cntB, tot_cntA, tot_cntB;
  logic [62:0] enc_A;
  logic [2:0]  enc_cntA, enc_cntB;
  logic [2:0]  enc_coarse;
  logic [6:0]  enc_fine;
  logic        enc_err;
  logic        out_valid, out_ready;
  logic [9:0]  out_toa, out_tot;
  logic [2:0]  out_flags;
  logic [7:0]  drop_cnt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  assign enc_coarse = enc_cntA + enc_cntB;
  assign enc_fine   = enc_A[6:0];
  assign enc_err    = enc_A[62];

  tdc_encode_scheduler #(.ENC_LAT(2), .TOT_TIMEOUT(15), .DROP_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .toa_valid  (toa_valid),
    .toa_raw    (toa_raw),
    .toa_cntA   (toa_cntA),
    .toa_cntB   (toa_cntB),
    .tot_valid  (tot_valid),
    .tot_raw    (tot_raw),
    .tot_cntA   (tot_cntA),
    .tot_cntB   (tot_cntB),
    .enc_A      (enc_A),
    .enc_cntA   (enc_cntA),
    .enc_cntB   (enc_cntB),
    .enc_coarse (enc_coarse),
    .enc_fine   (enc_fine),
    .enc_err    (enc_err),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_toa    (out_toa),
    .out_tot    (out_tot),
    .out_flags  (out_flags),
    .drop_cnt   (drop_cnt),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_until_valid(input int budget, output int edges);
    edges = 0;
    while (out_valid !== 1'b1 && edges < budget) begin
      tick();
      edges++;
    end
  endtask

  task automatic set_toa(input logic [62:0] raw, input logic [2:0] a, input logic [2:0] b);
    toa_raw = raw; toa_cntA = a; toa_cntB = b;
  endtask

  task automatic set_tot(input logic [62:0] raw, input logic [2:0] a, input logic [2:0] b);
    tot_raw = raw; tot_cntA = a; tot_cntB = b;
  endtask

  initial begin
    reset = 1'b1; toa_valid = 1'b0; tot_valid = 1'b0; out_ready = 1'b1;
    set_toa('0, '0, '0);
    set_tot('0, '0, '0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_enc_A", enc_A, 0);
    chk("rst_flags", out_flags, 0);
    reset = 1'b0;
    tick();

    // Basic pair: TOA at cycle 0, TOT at cycle 3
    set_toa(63'h1234_0000_0000_0021, 3'd3, 3'd2);
    set_tot(63'h0ABC_0000_0000_0040, 3'd1, 3'd1);
    toa_valid = 1'b1;
    tick();
    toa_valid = 1'b0;
    set_toa(63'h7FFF_FFFF_FFFF_FFFF, 3'd7, 3'd7);
    chk("basic_idle_busy", busy, 0);
    tick();
    chk("basic_seltoa_busy", busy, 1);
    chk("basic_seltoa_encA", enc_A, 63'h1234_0000_0000_0021);
    chk("basic_seltoa_cntA", enc_cntA, 3);
    tick();
    tot_valid = 1'b1;
    tick();
    tot_valid = 1'b0;
    chk("basic_wait_encA", enc_A, 0);
    chk("basic_wait_valid", out_valid, 0);
    tick();
    chk("basic_seltot_encA", enc_A, 63'h0ABC_0000_0000_0040);
    tick();
    chk("basic_e6_valid", out_valid, 0);
    tick();
    chk("basic_e7_valid", out_valid, 1);
    chk("basic_toa", out_toa, 10'h2A1);
    chk("basic_tot", out_tot, 10'h140);
    chk("basic_flags", out_flags, 3'b000);
    tick();
    chk("basic_after_valid", out_valid, 0);
    chk("basic_after_busy", busy, 0);

    // TOT timeout
    set_toa(63'h15, 3'd7, 3'd0);
    toa_valid = 1'b1;
    tick();
    toa_valid = 1'b0;
    run_until_valid(40, n);
    chk("tmo_latency", 1 + n, 19);
    chk("tmo_toa", out_toa, 10'h395);
    chk("tmo_tot", out_tot, 0);
    chk("tmo_flags", out_flags, 3'b100);
    tick();
    chk("tmo_after_valid", out_valid, 0);

    // Backpressure and drops
    out_ready = 1'b0;
    set_toa(63'h0A, 3'd1, 3'd0);
    set_tot(63'h4000_0000_0000_0033, 3'd2, 3'd2);
    toa_valid = 1'b1; tot_valid = 1'b1;
    tick();
    toa_valid = 1'b0; tot_valid = 1'b0;
    run_until_valid(30, n);
    chk("bp_latency", 1 + n, 7);
    chk("bp_toa", out_toa, 10'h08A);
    chk("bp_tot", out_tot, 10'h233);
    chk("bp_flags", out_flags, 3'b010);
    set_toa(63'h11, 3'd0, 3'd0);
    set_tot(63'h22, 3'd0, 3'd1);
    toa_valid = 1'b1; tot_valid = 1'b1;
    tick();
    toa_valid = 1'b0; tot_valid = 1'b0;
    chk("bp_fill_nodrop", drop_cnt, 0);
    set_toa(63'h7F, 3'd7, 3'd7);
    set_tot(63'h7F, 3'd7, 3'd7);
    toa_valid = 1'b1;
    tick(); tick(); tick();
    toa_valid = 1'b0;
    chk("bp_drop3", drop_cnt, 3);
    chk("bp_hold_valid", out_valid, 1);
    chk("bp_hold_toa", out_toa, 10'h08A);
    chk("bp_hold_tot", out_tot, 10'h233);
    toa_valid = 1'b1; tot_valid = 1'b1;
    tick();
    toa_valid = 1'b0; tot_valid = 1'b0;
    chk("bp_drop_both", drop_cnt, 5);
    out_ready = 1'b1;
    tick();
    chk("bp_release_valid", out_valid, 0);
    chk("bp_direct_busy", busy, 1);
    run_until_valid(30, n);
    chk("bp_rec2_latency", 1 + n, 6);
    chk("bp_rec2_toa", out_toa, 10'h011);
    chk("bp_rec2_tot", out_tot, 10'h0A2);
    chk("bp_rec2_flags", out_flags, 3'b000);
    tick();
    chk("bp_rec2_done", out_valid, 0);

    // Same-cycle load on the SEL_TOA release cycle
    set_toa(63'h0E, 3'd1, 3'd1);
    set_tot(63'h2F, 3'd3, 3'd0);
    toa_valid = 1'b1; tot_valid = 1'b1;
    tick();
    toa_valid = 1'b0; tot_valid = 1'b0;
    tick(); tick();
    set_toa(63'h01, 3'd4, 3'd0);
    toa_valid = 1'b1;
    tick();
    toa_valid = 1'b0;
    chk("same_nodrop", drop_cnt, 5);
    run_until_valid(20, n);
    chk("same_latency", 4 + n, 7);
    chk("same_toa", out_toa, 10'h10E);
    chk("same_tot", out_tot, 10'h1AF);
    tick();
    chk("same_release", out_valid, 0);
    run_until_valid(40, n);
    chk("same_rec2_latency", 1 + n, 18);
    chk("same_rec2_toa", out_toa, 10'h201);
    chk("same_rec2_tot", out_tot, 0);
    chk("same_rec2_flags", out_flags, 3'b100);
    tick();

    // Reset in the middle of SEL_TOT
    set_toa(63'h0A, 3'd1, 3'd0);
    set_tot(63'h4000_0000_0000_0033, 3'd2, 3'd2);
    toa_valid = 1'b1; tot_valid = 1'b1;
    tick();
    toa_valid = 1'b0; tot_valid = 1'b0;
    tick(); tick(); tick();
    toa_valid = 1'b1;
    tick();
    toa_valid = 1'b0;
    chk("mid_busy", busy, 1);
    chk("mid_seltot_encA", enc_A, 63'h4000_0000_0000_0033);
    reset = 1'b1;
    tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_encA", enc_A, 0);
    chk("mrst_toa", out_toa, 0);
    chk("mrst_tot", out_tot, 0);
    chk("mrst_flags", out_flags, 0);
    chk("mrst_drop", drop_cnt, 0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("mrst_holds_empty", busy, 0);
    set_toa(63'h1234_0000_0000_0021, 3'd3, 3'd2);
    set_tot(63'h0ABC_0000_0000_0040, 3'd1, 3'd1);
    toa_valid = 1'b1; tot_valid = 1'b1;
    tick();
    toa_valid = 1'b0; tot_valid = 1'b0;
    run_until_valid(30, n);
    chk("fresh_latency", 1 + n, 7);
    chk("fresh_toa", out_toa, 10'h2A1);
    chk("fresh_tot", out_tot, 10'h140);
    tick();

    // Saturation: TOT hold stays full in IDLE, every further strobe drops
    set_tot(63'h55, 3'd0, 3'd0);
    tot_valid = 1'b1;
    tick();
    chk("sat_first_capture", drop_cnt, 0);
    repeat (254) tick();
    chk("sat_254", drop_cnt, 254);
    tick();
    chk("sat_255", drop_cnt, 255);
    repeat (45) tick();
    tot_valid = 1'b0;
    chk("sat_300", drop_cnt, 255);
    chk("sat_tot_alone_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
